// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream carrying words drained from the async FIFO read side.
// The master drives data and valid. The slave (consumer) drives ready.
interface fifo_rd_stream_if #(
  parameter int DSIZE = 8
);
  logic [DSIZE-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-domain drain adapter: pops the async FIFO into a 2-entry buffer and presents a
// valid/ready stream, with a flush sequence and a saturating delivered-word count.
module fifo_rd_stream #(
  parameter int DSIZE = 8,
  parameter int CSIZE = 16
) (
  input  logic               rclk,
  input  logic               rrst_n,
  input  logic               rempty,
  input  logic [DSIZE-1:0]   rdata,
  output logic               rinc,
  fifo_rd_stream_if.master   m,
  input  logic               flush,
  output logic               flush_done,
  output logic [CSIZE-1:0]   word_cnt
);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]       state;
  logic [1:0]       cnt;
  logic [DSIZE-1:0] head_q;
  logic [DSIZE-1:0] tail_q;
  logic             xfer;

  function automatic logic [CSIZE-1:0] sat_inc(input logic [CSIZE-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Pop gating depends only on registered state and rempty, never on m_ready.
  always_comb begin
    rinc = 1'b0;
    case (state)
      ST_RUN:   rinc = !rempty && (cnt < 2'd2);
      ST_FLUSH: rinc = !rempty;
      default:  rinc = 1'b0;
    endcase
  end

  assign m.m_valid = (cnt != 2'd0);
  assign m.m_data  = head_q;
  assign xfer      = m.m_valid && m.m_ready;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state      <= ST_INIT;
      cnt        <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        ST_INIT: state <= ST_RUN;
        ST_RUN: begin
          if (flush) begin
            // A transfer on this edge is still counted; everything else is dropped.
            cnt   <= 2'd0;
            state <= ST_FLUSH;
          end else begin
            case ({rinc, xfer})
              2'b10: begin
                if (cnt == 2'd0) head_q <= rdata;
                else             tail_q <= rdata;
                cnt <= cnt + 2'd1;
              end
              2'b01: begin
                head_q <= tail_q;
                cnt    <= cnt - 2'd1;
              end
              2'b11: begin
                if (cnt == 2'd1) begin
                  head_q <= rdata;
                end else begin
                  head_q <= tail_q;
                  tail_q <= rdata;
                end
              end
              default: ;
            endcase
          end
        end
        ST_FLUSH: begin
          // Popped words are simply not stored; leave once the FIFO reads empty.
          if (rempty) begin
            state      <= ST_RUN;
            flush_done <= 1'b1;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) word_cnt <= '0;
    else if (xfer) word_cnt <= sat_inc(word_cnt);
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based FIFO/buffer reference model, directed scenarios
// plus randomized traffic, and a second instance with a 4-bit counter for saturation.
module tb_fifo_rd_stream;
  localparam int M_INIT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FLUSH = 2;

  logic        rclk = 1'b0;
  logic        rrst_n;
  logic        rempty;
  logic [7:0]  rdata;
  logic        rinc, rinc2;
  logic        flush;
  logic        flush_done, flush_done2;
  logic [15:0] word_cnt;
  logic [3:0]  word_cnt2;
  logic        m_ready;

  fifo_rd_stream_if #(.DSIZE(8)) s1 ();
  fifo_rd_stream_if #(.DSIZE(8)) s2 ();
  assign s1.m_ready = m_ready;
  assign s2.m_ready = m_ready;

  fifo_rd_stream #(.DSIZE(8), .CSIZE(16)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .m(s1), .flush(flush), .flush_done(flush_done), .word_cnt(word_cnt)
  );

  fifo_rd_stream #(.DSIZE(8), .CSIZE(4)) dut_s (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc2),
    .m(s2), .flush(flush), .flush_done(flush_done2), .word_cnt(word_cnt2)
  );

  always #5 rclk = ~rclk;

  logic [7:0] fifo_q[$];
  logic [7:0] bq[$];
  int         mode;
  int         wc;
  bit         fd;
  int         nchk, nerr;
  logic [7:0] wr_val;
  bit         c_rst, c_ready, c_flush, c_rinc, c_empty;
  int         nv, nfd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_rinc();
    if (mode == M_RUN)   return (fifo_q.size() != 0) && (bq.size() < 2);
    if (mode == M_FLUSH) return fifo_q.size() != 0;
    return 1'b0;
  endfunction

  task automatic drive_fifo();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? 8'h00 : fifo_q[0];
  endtask

  task automatic push_word(input logic [7:0] v);
    fifo_q.push_back(v);
    drive_fifo();
  endtask

  task automatic check_all();
    bit er;
    er = model_rinc();
    chk("rinc", rinc, er);
    chk("m_valid", s1.m_valid, bq.size() != 0);
    if (bq.size() != 0) chk("m_data", s1.m_data, bq[0]);
    chk("word_cnt", word_cnt, wc);
    chk("flush_done", flush_done, fd);
    chk("rinc_s", rinc2, er);
    chk("m_valid_s", s2.m_valid, bq.size() != 0);
    if (bq.size() != 0) chk("m_data_s", s2.m_data, bq[0]);
    chk("word_cnt_s", word_cnt2, (wc > 15) ? 15 : wc);
    chk("flush_done_s", flush_done2, fd);
  endtask

  task automatic model_reset();
    mode = M_INIT;
    bq.delete();
    wc = 0;
    fd = 1'b0;
  endtask

  // One clock: capture pre-edge inputs, advance the model after the edge, then compare.
  task automatic cycle();
    bit         xf;
    logic [7:0] w;
    c_rst   = !rrst_n;
    c_ready = m_ready;
    c_flush = flush;
    c_empty = (fifo_q.size() == 0);
    c_rinc  = model_rinc();
    xf      = (bq.size() != 0) && c_ready;
    w       = 8'h00;
    @(posedge rclk);
    #1;
    if (c_rst) begin
      model_reset();
    end else begin
      fd = 1'b0;
      if (xf) wc = (wc < 65535) ? wc + 1 : wc;
      if (c_rinc) w = fifo_q.pop_front();
      case (mode)
        M_INIT: mode = M_RUN;
        M_RUN: begin
          if (c_flush) begin
            bq.delete();
            mode = M_FLUSH;
          end else begin
            if (xf) void'(bq.pop_front());
            if (c_rinc) bq.push_back(w);
          end
        end
        default: begin
          if (c_empty) begin
            mode = M_RUN;
            fd   = 1'b1;
          end
        end
      endcase
    end
    drive_fifo();
    #1;
    check_all();
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 2) != 0 && fifo_q.size() < 16) begin
        push_word(wr_val);
        wr_val = wr_val + 8'd1;
      end
      cycle();
      flush = 1'b0;
    end
  endtask

  initial begin
    nchk = 0; nerr = 0;
    rrst_n = 1'b0; m_ready = 1'b0; flush = 1'b0; wr_val = 8'h40;
    model_reset();
    drive_fifo();
    #2;
    chk("rst_m_valid", s1.m_valid, 1'b0);
    chk("rst_m_data", s1.m_data, 8'h00);
    chk("rst_word_cnt", word_cnt, 16'd0);
    chk("rst_flush_done", flush_done, 1'b0);
    chk("rst_rinc", rinc, 1'b0);
    repeat (2) cycle();
    rrst_n = 1'b1;

    // Idle with an empty FIFO, then a single word arrives.
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("idle_rinc", rinc, 1'b0);
      chk("idle_valid", s1.m_valid, 1'b0);
    end
    push_word(8'hA5);
    #1;
    chk("lat_rinc", rinc, 1'b1);
    cycle();
    chk("lat_valid", s1.m_valid, 1'b1);
    chk("lat_data", s1.m_data, 8'hA5);
    m_ready = 1'b1;
    cycle();
    chk("lat_cnt", word_cnt, 16'd1);

    // Streaming 0x01..0x20 with m_ready held.
    for (int v = 1; v <= 32; v++) fifo_q.push_back(8'(v));
    drive_fifo();
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (s1.m_valid) nv++;
    end
    chk("stream_valid_cycles", nv, 32);
    chk("stream_cnt", word_cnt, 16'd33);
    chk("stream_idle", s1.m_valid, 1'b0);

    // Backpressure: only two pops while m_ready is low.
    m_ready = 1'b0;
    for (int v = 16; v < 24; v++) fifo_q.push_back(8'(v));
    drive_fifo();
    repeat (6) cycle();
    chk("bp_fifo_left", fifo_q.size(), 6);
    chk("bp_head", s1.m_data, 8'h10);
    chk("bp_rinc", rinc, 1'b0);
    m_ready = 1'b1;
    repeat (12) cycle();
    chk("bp_cnt", word_cnt, 16'd41);
    chk("bp_idle", s1.m_valid, 1'b0);

    // Flush with 0x30,0x31 buffered and five more words in the FIFO.
    m_ready = 1'b0;
    for (int v = 48; v < 55; v++) fifo_q.push_back(8'(v));
    drive_fifo();
    repeat (4) cycle();
    chk("fl_fifo_left", fifo_q.size(), 5);
    chk("fl_head", s1.m_data, 8'h30);
    m_ready = 1'b1;
    flush   = 1'b1;
    cycle();
    flush = 1'b0;
    chk("fl_cnt", word_cnt, 16'd42);
    chk("fl_valid", s1.m_valid, 1'b0);
    nfd = 0;
    for (int i = 0; i < 15; i++) begin
      cycle();
      if (flush_done) nfd++;
    end
    chk("fl_done_pulses", nfd, 1);
    chk("fl_cnt_after", word_cnt, 16'd42);
    chk("fl_valid_after", s1.m_valid, 1'b0);

    rand_cycles(1500);

    // Drain, fill the buffer, then reset mid-stream.
    m_ready = 1'b1;
    repeat (30) cycle();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_word(wr_val);
      wr_val = wr_val + 8'd1;
    end
    repeat (4) cycle();
    chk("pre_rst_valid", s1.m_valid, 1'b1);
    rrst_n = 1'b0;
    #1;
    chk("mrst_valid", s1.m_valid, 1'b0);
    chk("mrst_cnt", word_cnt, 16'd0);
    chk("mrst_cnt_s", word_cnt2, 4'd0);
    model_reset();
    fifo_q.delete();
    drive_fifo();
    repeat (2) cycle();
    for (int i = 0; i < 3; i++) begin
      push_word(wr_val);
      wr_val = wr_val + 8'd1;
    end
    rrst_n = 1'b1;
    #1;
    chk("init_rinc", rinc, 1'b0);
    cycle();
    chk("run_rinc", rinc, 1'b1);
    rand_cycles(1500);
    m_ready = 1'b1;
    repeat (30) cycle();
    chk("sat_cnt_s", word_cnt2, 4'd15);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain adapter for the dual-clock asynchronous FIFO, living entirely in the read clock domain. It pops words from the FIFO's read port (rempty/rinc/rdata) into a 2-entry output buffer and presents them on a valid/ready stream to the downstream consumer at full throughput. It also provides a flush sequence that discards all buffered and FIFO-resident data, and a saturating count of delivered words.

## Interface
- DSIZE, 8, data word width; matches the FIFO data width.
- CSIZE, 16, width of the delivered-word counter.

- rclk  in  1  read-domain clock; all state on rising edge.
- rrst_n  in  1  asynchronous active-low reset; same reset as the FIFO read side.
- rempty  in  1  FIFO empty flag, rclk domain, registered in the FIFO.
- rdata  in  DSIZE  FIFO read data; combinational view of the current read address, valid whenever rempty=0.
- rinc  out  1  FIFO pop; the read pointer advances at the rclk edge when rinc=1 and rempty=0.
- m_data  out  DSIZE  stream data, head of the output buffer.
- m_valid  out  1  stream data valid.
- m_ready  in  1  consumer ready; a transfer occurs on an edge with m_valid=1 and m_ready=1.
- flush  in  1  single-cycle flush request.
- flush_done  out  1  one-cycle pulse when a flush has completed.
- word_cnt  out  CSIZE  count of completed stream transfers; saturating.

## Operation
- State machine: INIT, RUN, FLUSH. Reset enters INIT. INIT moves to RUN unconditionally on the next edge.
- rinc is combinational from registered state and rempty only. There is no path from m_ready to rinc.
  - INIT: rinc=0.
  - RUN: rinc = !rempty && (cnt < 2).
  - FLUSH: rinc = !rempty.
- Buffer: 2 entries, FIFO order, with occupancy cnt in 0..2.
  - m_valid = (cnt != 0). m_data = head entry.
  - In RUN, on each edge: push rdata when rinc=1; pop the head on a transfer.
  - A push and a pop may occur on the same edge. Then cnt is unchanged and the pushed word enters behind the remaining entry, or becomes head if cnt was 1.
  - cnt never exceeds 2 and never underflows; the rinc gating guarantees this.
- word_cnt increments by 1 on each transfer edge, in any state, and holds at 2^CSIZE-1.
- Flush:
  - When flush=1 in RUN, the next state is FLUSH.
  - A transfer on that same edge still completes and is counted.
  - All other buffer entries are discarded, so cnt=0 after the edge. Any rinc pop on that edge is also discarded.
  - In FLUSH, m_valid=0 and every word popped is dropped.
  - When rempty=1 is sampled in FLUSH, the next state is RUN and flush_done=1 for exactly that following cycle.
  - Words written to the FIFO during FLUSH that arrive before rempty is seen high are dropped.
- flush asserted while in INIT or FLUSH is ignored.
- Reset asserted mid-operation: all state clears immediately. Buffered data is lost; the FIFO read pointer is reset by the same rrst_n.

## Timing
- Reset values: m_valid=0, m_data=0, flush_done=0, word_cnt=0, cnt=0, state=INIT. rinc=0 through the first cycle after release.
- Latency: if rempty falls in cycle N with RUN and cnt<2, then rinc=1 in cycle N, and m_valid=1 with that word on m_data in cycle N+1.
- Throughput: with rempty=0 and m_ready=1 held, one word is delivered per cycle in steady state (cnt stays 1).
- Backpressure: when m_ready is low, at most 2 further words are popped. Then rinc=0 until a transfer frees space.
- m_data and m_valid are stable while m_valid=1 and m_ready=0.
- Flush: request in cycle F with the FIFO already empty gives state FLUSH in F+1, rempty seen in F+1, and flush_done=1 in F+2.

## Test plan
- Reset/idle: hold rempty=1, release rrst_n → rinc=0, m_valid=0, word_cnt=0 for 10 cycles. Then rempty falls with rdata=8'hA5 → rinc=1 that cycle, and m_valid=1, m_data=8'hA5 next cycle.
- Streaming: FIFO holds 0x01..0x20 and m_ready=1 constantly → 32 transfers in 32 consecutive cycles after the first valid, in order; word_cnt=32; then m_valid=0.
- Backpressure: FIFO holds 0x10..0x17 with m_ready=0 → exactly 2 pops, m_data holds 0x10. Then raise m_ready → 0x10..0x17 delivered in order, no loss or duplication.
- Flush: buffer holds 0x30,0x31 and the FIFO holds 5 more words; pulse flush with m_ready=1 → 0x30 transfers and is counted (word_cnt +1). The remaining 6 words are dropped, flush_done pulses once after rempty=1, and m_valid=0 until new data arrives.
- Saturation: set CSIZE=4 and stream 20 words → word_cnt stops at 15.
- Mid-stream reset: assert rrst_n low while cnt=2 → m_valid=0 and word_cnt=0 immediately. After release, INIT lasts 1 cycle with rinc=0, then normal operation resumes.
